lsu_ctl: RTL and testbench

LSU_CTL -- requirements
Module: lsu_ctl

---
 rtl/lsu_ctl.sv | 164 ++++++++++++++++
 tb/tb_lsu_ctl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctl.sv
// Load/store unit controller: one outstanding access, byte-lane alignment of store data
// and extraction/extension of load data on a DATA_WIDTH memory bus.
module lsu_ctl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wr,
  input  logic [1:0]              i_req_size,
  input  logic                    i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic                    o_mem_wr,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_mask,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_misalign
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  // state | meaning
  // IDLE  | ready for a new request
  // REQ   | memory request presented, waiting for i_mem_ready
  // WAIT  | load issued, waiting for i_mem_rvalid
  // RSP   | one-cycle pipeline response
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t          state;
  logic            wr_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [OFFW-1:0] off_q;

  logic [OFFW-1:0]       req_off;
  logic [2:0]            low_bits;
  logic                  req_mis;
  logic [NB-1:0]         req_mask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [ADDR_WIDTH-1:0] req_addr;

  always_comb begin
    req_off = i_req_addr[OFFW-1:0];
    case (i_req_size)
      2'd0:    low_bits = 3'b000;
      2'd1:    low_bits = 3'b001;
      2'd2:    low_bits = 3'b011;
      default: low_bits = 3'b111;
    endcase
    req_mis = |(i_req_addr[2:0] & low_bits);
    for (int i = 0; i < NB; i++) begin
      req_mask[i] = (i >= int'(req_off)) && (i < int'(req_off) + (1 << i_req_size));
    end
    req_wdata = i_req_wdata << {req_off, 3'b000};
    req_addr  = {i_req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
  end

  // Load data: bring the addressed lanes down to bit 0, then extend above the access size.
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_sign;
  int                    ld_bits;

  always_comb begin
    ld_shift = i_mem_rdata >> {off_q, 3'b000};
    ld_bits  = DATA_WIDTH;
    ld_sign  = ld_shift[DATA_WIDTH-1];
    case (size_q)
      2'd0: begin ld_bits = 8;  ld_sign = ld_shift[7];  end
      2'd1: begin ld_bits = 16; ld_sign = ld_shift[15]; end
      2'd2: begin ld_bits = 32; ld_sign = ld_shift[31]; end
      default: ;
    endcase
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ld_data[i] = (i < ld_bits) ? ld_shift[i] : (ld_sign & ~uns_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= 2'd0;
      off_q          <= '0;
      o_req_ready    <= 1'b1;
      o_mem_valid    <= 1'b0;
      o_mem_wr       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
      o_mem_mask     <= '0;
      o_rsp_valid    <= 1'b0;
      o_rsp_rdata    <= '0;
      o_rsp_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            wr_q        <= i_req_wr;
            uns_q       <= i_req_unsigned;
            size_q      <= i_req_size;
            off_q       <= req_off;
            if (req_mis) begin
              state          <= RSP;
              o_rsp_valid    <= 1'b1;
              o_rsp_misalign <= 1'b1;
              o_rsp_rdata    <= '0;
            end else begin
              state       <= REQ;
              o_mem_valid <= 1'b1;
              o_mem_wr    <= i_req_wr;
              o_mem_addr  <= req_addr;
              o_mem_wdata <= req_wdata;
              o_mem_mask  <= req_mask;
            end
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
            if (wr_q) begin
              state       <= RSP;
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            state       <= RSP;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= ld_data;
          end
        end
        RSP: begin
          state          <= IDLE;
          o_req_ready    <= 1'b1;
          o_rsp_valid    <= 1'b0;
          o_rsp_rdata    <= '0;
          o_rsp_misalign <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctl.sv
// Randomized scoreboard bench for lsu_ctl (DATA_WIDTH=64): the driver queues expected
// memory requests and responses, an independent negedge monitor pops and compares.
module tb_lsu_ctl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wr;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic        o_mem_wr;
  logic [31:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_mask;
  logic        i_mem_rvalid;
  logic [63:0] i_mem_rdata;
  logic        o_rsp_valid;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_misalign;

  lsu_ctl #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_wr(i_req_wr), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_wr(o_mem_wr),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_misalign(o_rsp_misalign)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic        wr;
  } mem_t;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    int          lat;
  } rsp_t;

  mem_t mem_q[$];
  rsp_t rsp_q[$];
  int   acc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference behaviour from the access rules: byte lanes, masks, shift and extension.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [63:0] wd,
                                input logic [63:0] rd, output logic mis,
                                output logic [31:0] ea, output logic [63:0] ew,
                                output logic [7:0] em, output logic [63:0] er);
    int nb, off;
    logic [63:0] v, lo;
    nb  = 1 << sz;
    off = int'(addr % 32'd8);
    mis = (addr % 32'(nb)) != 32'd0;
    ea  = addr - 32'(off);
    em  = 8'(((1 << nb) - 1) << off);
    ew  = wd << (8 * off);
    v   = rd >> (8 * off);
    if (nb < 8) begin
      lo = (64'd1 << (8 * nb)) - 64'd1;
      v  = v & lo;
      if (!uns && ((v >> (8 * nb - 1)) & 64'd1) != 64'd0) v = v | ~lo;
    end
    er = (wr || mis) ? 64'd0 : v;
  endfunction

  mem_t        mexp;
  rsp_t        rexp;
  int          aexp;
  logic        pv = 1'b0;
  logic [31:0] pa;
  logic [63:0] pw;
  logic [7:0]  pm;
  logic        pwr;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      acc_q.delete();
      pv = 1'b0;
    end else begin
      if (i_req_valid && o_req_ready) acc_q.push_back(cyc);
      if (o_mem_valid) begin
        if (pv) begin
          check("mem_stable_addr", 64'(o_mem_addr), 64'(pa));
          check("mem_stable_wdata", o_mem_wdata, pw);
          check("mem_stable_ctl", 64'({o_mem_wr, o_mem_mask}), 64'({pwr, pm}));
        end
        if (i_mem_ready) begin
          if (mem_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL mem_unexpected: actual mem request addr=%h required none", o_mem_addr);
          end else begin
            mexp = mem_q.pop_front();
            check("mem_addr", 64'(o_mem_addr), 64'(mexp.addr));
            check("mem_wdata", o_mem_wdata, mexp.wdata);
            check("mem_mask", 64'(o_mem_mask), 64'(mexp.mask));
            check("mem_wr", 64'(o_mem_wr), 64'(mexp.wr));
          end
          pv = 1'b0;
        end else begin
          pv = 1'b1; pa = o_mem_addr; pw = o_mem_wdata; pm = o_mem_mask; pwr = o_mem_wr;
        end
      end else begin
        pv = 1'b0;
        check("mem_idle_zero", 64'({o_mem_wr, o_mem_mask}) | 64'(o_mem_addr) | o_mem_wdata, 64'd0);
      end
      if (o_rsp_valid) begin
        check("rsp_ready_low", 64'(o_req_ready), 64'd0);
        if (rsp_q.size() == 0 || acc_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: actual rsp_valid=1 rdata=%h required no response", o_rsp_rdata);
        end else begin
          rexp = rsp_q.pop_front();
          aexp = acc_q.pop_front();
          check("rsp_rdata", o_rsp_rdata, rexp.rdata);
          check("rsp_misalign", 64'(o_rsp_misalign), 64'(rexp.mis));
          check("rsp_latency", 64'(cyc - aexp), 64'(rexp.lat));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after its last memory-side action.
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int d, input int r, input bit rst_mid);
    logic mis, ev;
    logic [31:0] ea;
    logic [63:0] ew, er;
    logic [7:0] em;
    int n;
    model(wr, sz, uns, addr, wd, rd, mis, ea, ew, em, er);
    if (!mis) mem_q.push_back('{ea, ew, em, wr});
    if (!rst_mid) rsp_q.push_back('{er, mis, mis ? 1 : (wr ? 2 + d : 3 + d + r)});
    i_req_valid = 1'b1; i_req_wr = wr; i_req_size = sz; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wd;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_req_ready && n < 50);
    if (!o_req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: actual req_ready=0 required 1 within 50 cycles");
    end
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_req_wr = 1'($urandom_range(0, 1)); i_req_size = 2'($urandom_range(0, 3));
    i_req_unsigned = 1'($urandom_range(0, 1)); i_req_addr = $urandom; i_req_wdata = {$urandom, $urandom};
    if (mis) return;
    i_mem_ready = 1'b0;
    for (int j = 0; j < d; j++) begin @(posedge i_clk); #1; end
    i_mem_ready = 1'b1;
    ev = 1'($urandom_range(0, 1));
    i_mem_rvalid = ev; i_mem_rdata = {$urandom, $urandom};
    @(posedge i_clk); #1;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    if (wr) return;
    if (rst_mid) begin
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = rd;
      @(posedge i_clk); #1;
      i_mem_rvalid = 1'b0;
      return;
    end
    for (int j = 0; j < r; j++) begin @(posedge i_clk); #1; end
    i_mem_rvalid = 1'b1; i_mem_rdata = rd;
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0; i_mem_rdata = {$urandom, $urandom};
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    int gap;
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_addr = 32'd0; i_req_wdata = 64'd0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 64'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_req_ready", 64'(o_req_ready), 64'd1);
    check("reset_valids", 64'({o_mem_valid, o_rsp_valid, o_rsp_misalign, o_mem_wr}), 64'd0);
    check("reset_data", o_rsp_rdata | o_mem_wdata | 64'(o_mem_addr) | 64'(o_mem_mask), 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    do_txn(1'b1, 2'd0, 1'b0, 32'h1003, 64'hAB, 64'd0, 2, 0, 1'b0);
    do_txn(1'b0, 2'd1, 1'b0, 32'h2006, 64'd0, 64'h8001_0000_0000_0000, 1, 1, 1'b0);
    do_txn(1'b0, 2'd1, 1'b1, 32'h2006, 64'd0, 64'h8001_0000_0000_0000, 0, 0, 1'b0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h3002, 64'd0, 64'd0, 0, 0, 1'b0);
    do_txn(1'b0, 2'd3, 1'b0, 32'h0008, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0);
    do_txn(1'b1, 2'd3, 1'b0, 32'h0010, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 0, 0, 1'b0);

    do_txn(1'b0, 2'd2, 1'b0, 32'h0040, 64'd0, 64'h1234_5678, 1, 0, 1'b1);
    @(negedge i_clk);
    check("post_reset_ready", 64'(o_req_ready), 64'd1);
    for (int j = 0; j < 3; j++) begin
      check("post_reset_no_rsp", 64'(o_rsp_valid), 64'd0);
      @(negedge i_clk);
    end
    @(posedge i_clk); #1;

    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, {$urandom, $urandom},
             {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        i_mem_rvalid = 1'($urandom_range(0, 1)); i_mem_rdata = {$urandom, $urandom};
        @(posedge i_clk); #1;
      end
      i_mem_rvalid = 1'b0;
    end

    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    check("mem_queue_drained", 64'(mem_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
